// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store initiator for a 64-word memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       res_q, res_d;
  logic              err_q;
  logic              req_err;
  logic              accept;

  function automatic logic is_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic e;
    e = 1'b0;
    unique case (1'b1)
      (f3 == 3'b011), (f3 == 3'b110),
      (f3 == 3'b111):  e = 1'b1;
      (we && f3[2]):   e = 1'b1;
      (f3[1:0] == 2'b01): e = a[0];
      (f3[1:0] == 2'b10): e = (a != 2'b00);
      default:         e = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] extract(
    input logic [2:0]  f3,
    input logic [1:0]  o,
    input logic [31:0] w
  );
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {o, 3'b000};
    b  = sh[7:0];
    h  = o[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [2:0]  f3,
    input logic [1:0]  o,
    input logic [31:0] w,
    input logic [31:0] d
  );
    logic [31:0] m;
    m = w;
    if (f3[1:0] == 2'b00)
      m[{o, 3'b000} +: 8] = d[7:0];
    else
      m[{o[1], 4'b0000} +: 16] = d[15:0];
    return m;
  endfunction

  assign req_err = is_err(req_we, req_funct3, req_addr[1:0]);
  assign accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)
            state_d = RESP;
          else if (req_we && req_funct3 == 3'b010)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by rst so an abort drops mem_write immediately.
  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = rst;
      READ:    mem_read  = rst;
      WRITE:   mem_write = rst;
      RESP:    rsp_valid = rst;
      default: ;
    endcase
  end

  always_comb begin
    res_d = res_q;
    if (accept)
      res_d = 32'h0;
    else if (state_q == READ)
      res_d = we_q ? merge(f3_q, addr_q[1:0], mem_rdata, wdata_q)
                   : extract(f3_q, addr_q[1:0], mem_rdata);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      res_q   <= 32'h0;
    end else begin
      res_q <= res_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
    end
  end

  assign mem_addr   = addr_q[ADDR_W-1:2];
  assign mem_funct3 = 3'b010;
  assign mem_wdata  = !mem_write ? 32'h0
                    : (f3_q == 3'b010) ? wdata_q : res_q;
  assign rsp_err    = rsp_valid && err_q;
  assign rsp_rdata  = (rsp_valid && !we_q && !err_q) ? res_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus reset/abort sequences
// against a 64-word behavioural memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  int n_cmp  = 0;
  int n_fail = 0;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write) mem[mem_addr] <= mem_wdata;

  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          k;
    logic        err;
    logic [31:0] rd;
    int          rdk;
    int          wrk;
    logic [31:0] wdx;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int rsp_k, rd_k, rd_n, wr_k, wr_n;
    logic [31:0] rd_v, wd_v;
    logic er_v, both, bad_addr;
    rsp_k = 0; rd_k = 0; rd_n = 0; wr_k = 0; wr_n = 0;
    rd_v = 0; wd_v = 0; er_v = 0; both = 0; bad_addr = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wd;
    chk({nm, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_read && mem_write) both = 1'b1;
      if ((mem_read || mem_write) && mem_addr != v.addr[7:2])
        bad_addr = 1'b1;
      if (mem_read) begin
        rd_n++;
        if (rd_k == 0) rd_k = k;
      end
      if (mem_write) begin
        wr_n++;
        if (wr_k == 0) wr_k = k;
        wd_v = mem_wdata;
      end
      if (rsp_valid) begin
        rsp_k = k;
        rd_v  = rsp_rdata;
        er_v  = rsp_err;
        break;
      end
    end
    if (rsp_k == 0)
      $display("FAIL %s_timeout: no rsp_valid within 8 cycles", nm);
    chk({nm, "_rsp_k"}, rsp_k, v.k);
    chk({nm, "_err"}, {31'h0, er_v}, {31'h0, v.err});
    chk({nm, "_rdata"}, rd_v, v.rd);
    chk({nm, "_rd_k"}, rd_k, v.rdk);
    chk({nm, "_rd_n"}, rd_n, (v.rdk != 0) ? 1 : 0);
    chk({nm, "_wr_k"}, wr_k, v.wrk);
    chk({nm, "_wr_n"}, wr_n, (v.wrk != 0) ? 1 : 0);
    if (v.wrk != 0) chk({nm, "_wdata"}, wd_v, v.wdx);
    chk({nm, "_both"}, {31'h0, both}, 32'h0);
    chk({nm, "_addr"}, {31'h0, bad_addr}, 32'h0);
    @(negedge clk);
    chk({nm, "_pulse"}, {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'h0);
    chk({nm, "_idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, {31'h0, req_ready}, 32'h0);
    chk({nm, "_strb"}, {29'h0, rsp_valid, mem_read, mem_write}, 32'h0);
    chk({nm, "_rsp"}, {31'h0, rsp_err}, 32'h0);
    chk({nm, "_rdata"}, rsp_rdata, 32'h0);
    chk({nm, "_maddr"}, {26'h0, mem_addr}, 32'h0);
    chk({nm, "_wdata"}, mem_wdata, 32'h0);
    chk({nm, "_f3"}, {29'h0, mem_funct3}, 32'h2);
  endtask

  initial begin
    logic seen;
    vec_t lw;
    vt[0]  = '{1'b1, 3'b010, 8'h08, 32'hDEADBEEF, 2, 1'b0, 32'h0, 0, 1, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 3'b010, 8'h08, 32'h0, 2, 1'b0, 32'hDEADBEEF, 1, 0, 32'h0};
    vt[2]  = '{1'b1, 3'b010, 8'h08, 32'h80FF7F01, 2, 1'b0, 32'h0, 0, 1, 32'h80FF7F01};
    vt[3]  = '{1'b0, 3'b000, 8'h0B, 32'h0, 2, 1'b0, 32'hFFFFFF80, 1, 0, 32'h0};
    vt[4]  = '{1'b0, 3'b100, 8'h0B, 32'h0, 2, 1'b0, 32'h00000080, 1, 0, 32'h0};
    vt[5]  = '{1'b0, 3'b001, 8'h0A, 32'h0, 2, 1'b0, 32'hFFFF80FF, 1, 0, 32'h0};
    vt[6]  = '{1'b0, 3'b101, 8'h0A, 32'h0, 2, 1'b0, 32'h000080FF, 1, 0, 32'h0};
    vt[7]  = '{1'b0, 3'b000, 8'h08, 32'h0, 2, 1'b0, 32'h00000001, 1, 0, 32'h0};
    vt[8]  = '{1'b0, 3'b010, 8'h08, 32'h0, 2, 1'b0, 32'h80FF7F01, 1, 0, 32'h0};
    vt[9]  = '{1'b1, 3'b000, 8'h09, 32'h123456AA, 3, 1'b0, 32'h0, 1, 2, 32'h80FFAA01};
    vt[10] = '{1'b1, 3'b010, 8'h08, 32'h80FF7F01, 2, 1'b0, 32'h0, 0, 1, 32'h80FF7F01};
    vt[11] = '{1'b1, 3'b001, 8'h0A, 32'h0000BEEF, 3, 1'b0, 32'h0, 1, 2, 32'hBEEF7F01};
    vt[12] = '{1'b0, 3'b010, 8'h08, 32'h0, 2, 1'b0, 32'hBEEF7F01, 1, 0, 32'h0};
    vt[13] = '{1'b0, 3'b010, 8'h06, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[14] = '{1'b1, 3'b001, 8'h05, 32'h0000FFFF, 1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[15] = '{1'b0, 3'b011, 8'h00, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[16] = '{1'b1, 3'b100, 8'h00, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[17] = '{1'b0, 3'b101, 8'h0B, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0};

    rst        = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 8'h08;
    req_wdata  = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_mem_untouched", mem[2], 32'h0);

    for (int i = 0; i < 18; i++)
      run_vec(vt[i], $sformatf("v%0d", i));

    // Abort an SH during READ: no write, no response, word intact.
    lw = '{1'b1, 3'b010, 8'h08, 32'h11223344, 2, 1'b0, 32'h0, 0, 1, 32'h11223344};
    run_vec(lw, "abort_setup");
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 8'h0A;
    req_wdata  = 32'h00005555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_read", {31'h0, mem_read}, 32'h1);
    rst = 1'b0;
    seen = 1'b0;
    #1;
    chk_zero("abort_rst");
    repeat (3) begin
      @(negedge clk);
      if (mem_write || rsp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_write || rsp_valid) seen = 1'b1;
    end
    chk("abort_no_activity", {31'h0, seen}, 32'h0);
    chk("abort_mem_word", mem[2], 32'h11223344);
    lw = '{1'b0, 3'b010, 8'h08, 32'h0, 2, 1'b0, 32'h11223344, 1, 0, 32'h0};
    run_vec(lw, "abort_lw");

    // Abort an SW while mem_write is high: strobe must drop at once.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 8'h10;
    req_wdata  = 32'hAAAAAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_sw_in_write", {31'h0, mem_write}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_sw_drop", {31'h0, mem_write}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sw_mem_word", mem[4], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
